// File: rtl/core_sequencer_pkg.sv
// Shared state encodings and datapath select constants for the core sequencer.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] WB_NONE  = 2'd0;
  localparam logic       ADDR_PC  = 1'b0;
  localparam logic       ADDR_ALU = 1'b1;
  localparam logic       PC_SEQ   = 1'b0;
  localparam logic       PC_TGT   = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles; flags a timeout on the
// MAX_WAIT-th consecutive stalled cycle.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  logic [WAIT_W-1:0] r_cnt;
  logic              w_stall;

  assign w_stall   = i_active & ~i_ready;
  assign o_timeout = w_stall & (r_cnt == WAIT_W'(MAX_WAIT - 1));

  // Leaving the active state only happens on ready or timeout, so clearing on
  // those (and whenever inactive) covers every state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!w_stall || o_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM and shared memory-port arbiter for the core.
// Optional performance counters are enabled by defining MYRV_PERF_CNT_EN.
//
// state  | meaning
// FETCH  | instruction fetch on PC address, load IR on ready
// DECODE | register-file read
// EXEC   | ALU cycle, choose MEM or WB
// MEM    | data access on ALU address, load MDR on ready for loads
// WB     | register write and PC update
// HALT   | bus timeout, wait for reset
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dec_mem,
  input  logic       i_dec_mem_read,
  input  logic       i_dec_branch,
  input  logic       i_dec_uncond,
  input  logic [1:0] i_dec_wb,
  input  logic       i_cmp_result,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_addr_sel,
  output logic       o_ir_we,
  output logic       o_mdr_we,
  output logic       o_rf_we,
  output logic       o_pc_we,
  output logic       o_pc_src,
  output logic       o_bus_err,
  output logic [2:0] o_state
`ifdef MYRV_PERF_CNT_EN
  ,
  output logic [63:0] o_cycle_cnt,
  output logic [63:0] o_instret_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  logic   r_bus_err;
  logic   w_active;
  logic   w_timeout;
  logic   w_req, w_we, w_asel, w_ir, w_mdr, w_rf, w_pcw, w_pcs;

  assign w_active = (r_state == ST_FETCH) || (r_state == ST_MEM);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) u_wait (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_active (w_active),
    .i_ready  (i_mem_ready),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_FETCH;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_we   = 1'b0;
    w_asel = ADDR_PC;
    w_ir   = 1'b0;
    w_mdr  = 1'b0;
    w_rf   = 1'b0;
    w_pcw  = 1'b0;
    w_pcs  = PC_SEQ;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (i_mem_ready) begin
          w_ir   = 1'b1;
          w_next = ST_DECODE;
        end else if (w_timeout) begin
          w_next = ST_HALT;
        end
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = i_dec_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        w_req  = 1'b1;
        w_asel = ADDR_ALU;
        w_we   = ~i_dec_mem_read;
        if (i_mem_ready) begin
          w_mdr  = i_dec_mem_read;
          w_next = ST_WB;
        end else if (w_timeout) begin
          w_next = ST_HALT;
        end
      end
      ST_WB: begin
        w_rf   = (i_dec_wb != WB_NONE) | (i_dec_mem & i_dec_mem_read);
        w_pcw  = 1'b1;
        w_pcs  = (i_dec_branch & (i_dec_uncond | i_cmp_result)) ? PC_TGT : PC_SEQ;
        w_next = ST_FETCH;
      end
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_HALT;
    endcase
  end

  // Reset masks the request immediately so the bus drops a pending transaction.
  assign o_mem_req  = ~i_rst & w_req;
  assign o_mem_we   = ~i_rst & w_we;
  assign o_addr_sel = ~i_rst & w_asel;
  assign o_ir_we    = ~i_rst & w_ir;
  assign o_mdr_we   = ~i_rst & w_mdr;
  assign o_rf_we    = ~i_rst & w_rf;
  assign o_pc_we    = ~i_rst & w_pcw;
  assign o_pc_src   = ~i_rst & w_pcs;
  assign o_bus_err  = r_bus_err;
  assign o_state    = r_state;

`ifdef MYRV_PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != ST_HALT) r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (r_state == ST_WB)   r_instret_cnt <= r_instret_cnt + 64'd1;
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`endif

endmodule
